// File: rtl/sprite_tile_fetcher_if.sv
// Bundle of the request, sprite ROM and pixel stream signals around sprite_tile_fetcher.
// slave is the fetcher itself; master is the scene logic, ROM and renderer driving it.
interface sprite_tile_fetcher_if #(
  parameter int PIX_W = 12
);
  logic             req_valid;
  logic [5:0]       req_id;
  logic             req_mirror;
  logic             req_ready;
  logic             rom_en;
  logic [17:0]      rom_addr;
  logic [PIX_W-1:0] rom_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic [5:0]       pix_x;
  logic [5:0]       pix_y;
  logic             pix_last;
  logic             busy;

  modport slave (
    input  req_valid, req_id, req_mirror, rom_data, pix_ready,
    output req_ready, rom_en, rom_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy
  );

  modport master (
    output req_valid, req_id, req_mirror, rom_data, pix_ready,
    input  req_ready, rom_en, rom_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy
  );
endinterface

// File: rtl/sprite_tile_fetcher.sv
// Streams one 64x64 tile of the 640-wide sprite sheet through a credit-limited ROM pipeline.
// Define SPRITE_MIRROR_EN to enable horizontally mirrored ROM reads.
module sprite_tile_fetcher #(
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_W      = 12
) (
  input logic                  clk,
  input logic                  rst,
  sprite_tile_fetcher_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = $clog2(ROM_LAT + 1);
  localparam logic [17:0] SKY_BASE = 18'd163840;
  localparam logic [17:0] ROW_STEP = 18'd640;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;

  state_t            r_state, w_nextState;
  logic [5:0]        r_id;
  logic [17:0]       r_rowBase;
  logic [5:0]        r_x, r_y;
  logic [ROM_LAT-1:0] r_tokValid;
  logic [5:0]        r_tokX [ROM_LAT];
  logic [5:0]        r_tokY [ROM_LAT];
  logic [PIX_W-1:0]  r_fifoData [FIFO_DEPTH];
  logic [5:0]        r_fifoX [FIFO_DEPTH];
  logic [5:0]        r_fifoY [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic [2:0]        w_row;
  logic [3:0]        w_colTile;
  logic [17:0]       w_base;
  logic [5:0]        w_col;
  logic [LAT_W-1:0]  w_inFlight;
  logic [7:0]        w_used;
  logic              w_issue, w_push, w_pop, w_pixValid;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_row     = 3'(r_id / 6'd10);
    w_colTile = 4'(r_id % 6'd10);
    if (r_id == 6'd41 || r_id == 6'd47 || r_id >= 6'd50) w_base = SKY_BASE;
    else w_base = 18'(w_row) * 18'd40960 + 18'(w_colTile) * 18'd64;
  end

`ifdef SPRITE_MIRROR_EN
  logic r_mirror;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mirror <= 1'b0;
    else if (r_state == IDLE && bus.req_valid) r_mirror <= bus.req_mirror;
  end

  assign w_col = r_mirror ? (6'd63 - r_x) : r_x;
`else
  assign w_col = r_x;
`endif

  always_comb begin
    w_inFlight = '0;
    for (int i = 0; i < ROM_LAT; i++) w_inFlight = w_inFlight + LAT_W'(r_tokValid[i]);
  end

  assign w_pixValid = (r_count != '0);
  assign w_pop      = w_pixValid && bus.pix_ready;
  assign w_push     = r_tokValid[ROM_LAT-1];
  // A pop this cycle frees its slot in time for a read issued now, keeping 1 pixel/cycle.
  assign w_used     = 8'(w_inFlight) + 8'(r_count) - 8'(w_pop);

  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE:  if (bus.req_valid) w_nextState = LOAD;
      LOAD:  w_nextState = ISSUE;
      ISSUE: begin
        w_issue = (w_used < 8'(FIFO_DEPTH));
        if (w_issue && r_x == 6'd63 && r_y == 6'd63) w_nextState = DRAIN;
      end
      DRAIN: if (r_count == '0 && w_inFlight == '0) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_rowBase <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && bus.req_valid) r_id <= bus.req_id;
      if (r_state == LOAD) begin
        r_rowBase <= w_base;
        r_x       <= '0;
        r_y       <= '0;
      end else if (w_issue) begin
        r_x <= r_x + 6'd1;
        if (r_x == 6'd63) begin
          r_y       <= r_y + 6'd1;
          r_rowBase <= r_rowBase + ROW_STEP;
        end
      end
    end
  end

  // Each token carries the output-order coordinates of one outstanding ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tokValid <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_tokX[i] <= '0;
        r_tokY[i] <= '0;
      end
    end else begin
      r_tokValid[0] <= w_issue;
      r_tokX[0]     <= r_x;
      r_tokY[0]     <= r_y;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_tokValid[i] <= r_tokValid[i-1];
        r_tokX[i]     <= r_tokX[i-1];
        r_tokY[i]     <= r_tokY[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifoData[i] <= '0;
        r_fifoX[i]    <= '0;
        r_fifoY[i]    <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifoData[r_wrPtr] <= bus.rom_data;
        r_fifoX[r_wrPtr]    <= r_tokX[ROM_LAT-1];
        r_fifoY[r_wrPtr]    <= r_tokY[ROM_LAT-1];
        r_wrPtr             <= nextPtr(r_wrPtr);
      end
      if (w_pop) r_rdPtr <= nextPtr(r_rdPtr);
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rom_en    = w_issue;
  assign bus.rom_addr  = r_rowBase + 18'(w_col);
  assign bus.pix_valid = w_pixValid;
  assign bus.pix_data  = r_fifoData[r_rdPtr];
  assign bus.pix_x     = r_fifoX[r_rdPtr];
  assign bus.pix_y     = r_fifoY[r_rdPtr];
  assign bus.pix_last  = w_pixValid && (r_fifoX[r_rdPtr] == 6'd63) && (r_fifoY[r_rdPtr] == 6'd63);
endmodule
